// File: rtl/rvx_core_load_unit_pkg.sv
// Shared load-unit definitions: RV32 load funct3 codes, FSM state encoding and
// the alignment rule used when misaligned loads trap.
package rvx_core_load_unit_pkg;

  localparam logic [2:0] RISCV_FUNCT3_LB  = 3'b000;
  localparam logic [2:0] RISCV_FUNCT3_LH  = 3'b001;
  localparam logic [2:0] RISCV_FUNCT3_LW  = 3'b010;
  localparam logic [2:0] RISCV_FUNCT3_LBU = 3'b100;
  localparam logic [2:0] RISCV_FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    LS_IDLE      = 2'd0,
    LS_WAIT_RESP = 2'd1,
    LS_DRAIN     = 2'd2
  } load_state_e;

  // Undefined funct3 codes are treated as word accesses.
  function automatic logic load_is_misaligned(input logic [2:0] funct3,
                                              input logic [1:0] offset);
    logic mis;
    case (funct3)
      RISCV_FUNCT3_LB, RISCV_FUNCT3_LBU: mis = 1'b0;
      RISCV_FUNCT3_LH, RISCV_FUNCT3_LHU: mis = offset[0];
      default:                           mis = (offset != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rvx_core_load_aligner.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// word-aligned read word and sign- or zero-extends it per funct3.
module rvx_core_load_aligner
  import rvx_core_load_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] read_data,
  output logic [31:0] aligned_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = read_data[7:0];
    case (offset)
      2'd0: byte_sel = read_data[7:0];
      2'd1: byte_sel = read_data[15:8];
      2'd2: byte_sel = read_data[23:16];
      2'd3: byte_sel = read_data[31:24];
      default: byte_sel = read_data[7:0];
    endcase
  end

  // Halfwords ignore offset[0]; misaligned halfwords are truncated down.
  assign half_sel = offset[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    aligned_data = read_data;
    case (funct3)
      RISCV_FUNCT3_LB:  aligned_data = {{24{byte_sel[7]}}, byte_sel};
      RISCV_FUNCT3_LBU: aligned_data = {24'd0, byte_sel};
      RISCV_FUNCT3_LH:  aligned_data = {{16{half_sel[15]}}, half_sel};
      RISCV_FUNCT3_LHU: aligned_data = {16'd0, half_sel};
      default:          aligned_data = read_data;
    endcase
  end

endmodule

// File: rtl/rvx_core_load_unit.sv
// Data-memory load unit: issues the read for an s1 load, stalls until the
// response, delivers the formatted result registered to s2.
// Optional misaligned-load trap: define RVX_LOAD_MISALIGNED_TRAP_EN.
module rvx_core_load_unit
  import rvx_core_load_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_s1,
  input  logic [2:0]  funct3_s1,
  input  logic [1:0]  target_address_adder_1_0_s1,
  input  logic        flush,
  output logic        read_request,
  input  logic        read_request_ready,
  input  logic [31:0] read_data,
  input  logic        read_valid,
  output logic [31:0] load_data_s2,
  output logic        load_valid_s2,
  output logic        stall_load,
  output logic        misaligned_load
);

  load_state_e state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        mis_s1;
  logic [31:0] aligned_data;

`ifdef RVX_LOAD_MISALIGNED_TRAP_EN
  assign mis_s1 = load_is_misaligned(funct3_s1, target_address_adder_1_0_s1);
`else
  assign mis_s1 = 1'b0;
`endif

  rvx_core_load_aligner u_aligner (
    .funct3       (funct3_q),
    .offset       (offset_q),
    .read_data    (read_data),
    .aligned_data (aligned_data)
  );

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    read_request = 1'b0;
    stall_load   = 1'b0;
    case (state_q)
      LS_IDLE: begin
        read_request = load_s1 & ~flush & ~mis_s1;
        stall_load   = read_request & ~read_request_ready;
        misaligned_d = load_s1 & ~flush & mis_s1;
        if (read_request && read_request_ready) begin
          funct3_d = funct3_s1;
          offset_d = target_address_adder_1_0_s1;
          state_d  = LS_WAIT_RESP;
        end
      end
      LS_WAIT_RESP: begin
        stall_load = 1'b1;
        if (read_valid) begin
          state_d = LS_IDLE;
          if (!flush) begin
            load_data_d  = aligned_data;
            load_valid_d = 1'b1;
          end
        end else if (flush) begin
          state_d = LS_DRAIN;
        end
      end
      LS_DRAIN: begin
        // The killed request's response still owes us a beat; swallow it.
        stall_load = load_s1;
        if (read_valid) state_d = LS_IDLE;
      end
      default: state_d = LS_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LS_IDLE;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign load_data_s2    = load_data_q;
  assign load_valid_s2   = load_valid_q;
  assign misaligned_load = misaligned_q;

endmodule
